input_vc_buffer: RTL and testbench

Per-port virtual-channel buffer that sits directly downstream of the input router. It accepts 8-bit flits and, for each packet, latches the router's 2-bit `vc_select` on the head flit. It steers that packet's head, body and tail flits into one of four direction FIFOs (VC0..VC3) and presents each FIFO head, first-word-fall-through, to the switch allocator with per-VC valid/ready handshakes.

---
 rtl/input_vc_buffer.sv | 153 +++++++++++++++
 tb/tb_input_vc_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_vc_buffer.sv
// input_vc_buffer
//   Per-port virtual-channel buffer placed after the input router. Flits are
//   steered into one of four FIFOs. The route is taken from vc_select on head
//   and single flits, and from the latched cur_vc on body and tail flits. Each
//   FIFO presents its head flit to the switch allocator first-word-fall-through.
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset
//   in_valid   flit valid this cycle
//   in_ready   buffer accepts flit this cycle (combinational)
//   flit       8-bit flit, [7:6] type: 01 head, 00 body, 10 tail, 11 single
//   vc_select  2-bit route, sampled on head/single only
//   out_valid  per-VC non-empty
//   out_flit   VC i head flit on [8i+7:8i]
//   out_ready  per-VC pop request
//   vc_count   VC i occupancy on [(AW+1)(i+1)-1:(AW+1)i]
//   proto_err  one-cycle pulse, the cycle after a framing violation is dropped
//
// Write-side FSM
//   state  | meaning
//   IDLE   | between packets; expect head or single
//   IN_PKT | head seen; expect body or tail routed to cur_vc
module input_vc_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            flit,
    input  logic [1:0]            vc_select,
    output logic [3:0]            out_valid,
    output logic [31:0]           out_flit,
    input  logic [3:0]            out_ready,
    output logic [4*(AW+1)-1:0]   vc_count,
    output logic                  proto_err
);

    localparam int CW = AW + 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t      state_q;
    logic [1:0]  cur_vc_q;
    logic        proto_err_q;

    logic [AW:0] wr_ptr_q [4];
    logic [AW:0] rd_ptr_q [4];
    logic [7:0]  mem_q    [4][DEPTH];

    logic        starts_pkt;
    logic        ends_pkt;
    logic        framing_bad;
    logic [1:0]  tgt_vc;
    logic [3:0]  full;
    logic [3:0]  empty;
    logic        push;
    logic [3:0]  push_vec;
    logic [3:0]  pop_vec;

    // Head (01) and single (11) both open a packet; tail (10) and single close one.
    assign starts_pkt = flit[6];
    assign ends_pkt   = flit[7];

    // Out-of-place flits are consumed (in_ready forced high) so the link never stalls.
    assign framing_bad = (state_q == IDLE) ? !starts_pkt : starts_pkt;
    assign tgt_vc      = starts_pkt ? vc_select : cur_vc_q;

    always_comb begin
        full  = '0;
        empty = '0;
        for (int i = 0; i < 4; i++) begin
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                       (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
        end
    end

    // A same-cycle pop does not free space for a write; full refuses outright.
    assign in_ready = framing_bad ? 1'b1 : !full[tgt_vc];
    assign push     = in_valid && in_ready && !framing_bad;

    always_comb begin
        push_vec = '0;
        pop_vec  = '0;
        for (int i = 0; i < 4; i++) begin
            push_vec[i] = push && (tgt_vc == 2'(i));
            pop_vec[i]  = !empty[i] && out_ready[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cur_vc_q    <= 2'd0;
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= in_valid && framing_bad;
            case (state_q)
                IDLE: begin
                    if (push && !ends_pkt) begin
                        state_q  <= IN_PKT;
                        cur_vc_q <= vc_select;
                    end
                end
                IN_PKT: begin
                    if (push && ends_pkt) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push_vec[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_ONE;
                if (pop_vec[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_ONE;
            end
        end
    end

    // Storage is intentionally not reset; out_flit is only meaningful with out_valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push_vec[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= flit;
        end
    end

    always_comb begin
        out_flit  = '0;
        vc_count  = '0;
        out_valid = '0;
        for (int i = 0; i < 4; i++) begin
            out_valid[i]         = !empty[i];
            out_flit[8*i +: 8]   = mem_q[i][rd_ptr_q[i][AW-1:0]];
            vc_count[CW*i +: CW] = wr_ptr_q[i] - rd_ptr_q[i];
        end
    end

    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_input_vc_buffer.sv
module tb_input_vc_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int CW    = AW + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        flit;
    logic [1:0]        vc_select;
    logic [3:0]        out_valid;
    logic [31:0]       out_flit;
    logic [3:0]        out_ready;
    logic [4*CW-1:0]   vc_count;
    logic              proto_err;

    input_vc_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flit      (flit),
        .vc_select (vc_select),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_ready (out_ready),
        .vc_count  (vc_count),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one expected-flit queue per VC plus framing state.
    logic [7:0] q0[$], q1[$], q2[$], q3[$];
    logic       m_inpkt;
    logic [1:0] m_cur;
    logic       m_perr;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [7:0] qpop(input int i);
        case (i)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    function automatic void qpush(input int i, input logic [7:0] d);
        case (i)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endfunction

    function automatic int cnt(input int i);
        logic [CW-1:0] c;
        c = vc_count[CW*i +: CW];
        return int'(c);
    endfunction

    // Drive one cycle at the falling edge, compare against the model mid-cycle,
    // then advance the model to what the rising edge should produce.
    task automatic drive(input logic v, input logic [7:0] f, input logic [1:0] sel,
                         input logic [3:0] ordy);
        logic starts, illegal, exp_rdy;
        int   tgt;
        logic [7:0] exp_f, got_f;
        @(negedge clk);
        in_valid  = v;
        flit      = f;
        vc_select = sel;
        out_ready = ordy;
        #1;
        starts  = (f[7:6] == 2'b01) || (f[7:6] == 2'b11);
        illegal = m_inpkt ? starts : !starts;
        tgt     = starts ? int'(sel) : int'(m_cur);
        exp_rdy = illegal || (qsize(tgt) < DEPTH);
        check("in_ready", int'(in_ready), int'(exp_rdy));
        check("proto_err", int'(proto_err), int'(m_perr));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("out_valid[%0d]", i), int'(out_valid[i]), int'(qsize(i) != 0));
            check($sformatf("vc_count[%0d]", i), cnt(i), qsize(i));
            if (qsize(i) != 0 && ordy[i]) begin
                got_f = out_flit[8*i +: 8];
                exp_f = qpop(i);
                check($sformatf("out_flit[%0d]", i), int'(got_f), int'(exp_f));
            end
        end
        if (v && !illegal && exp_rdy) begin
            qpush(tgt, f);
            if (f[7:6] == 2'b01) begin
                m_inpkt = 1'b1;
                m_cur   = sel;
            end else if (f[7:6] == 2'b10) begin
                m_inpkt = 1'b0;
            end
        end
        m_perr = v && illegal;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        m_inpkt = 1'b0;
        m_cur   = 2'd0;
        m_perr  = 1'b0;
        check("rst out_valid", int'(out_valid), 0);
        check("rst vc_count", int'(vc_count), 0);
        check("rst proto_err", int'(proto_err), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 2; k++) drive(1'b0, 8'h00, 2'd0, 4'hF);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] f;
        logic [1:0] sel;
        logic [3:0] ordy;
        logic       exp_rdy;
        int         exp_cnt2;
        logic [7:0] exp_flit2;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Single-VC packet to VC2, drain, then a stray body from IDLE.
        vecs[0] = '{1'b1, 8'h41, 2'd2, 4'b0000, 1'b1, 0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 8'h05, 2'd0, 4'b0000, 1'b1, 1, 8'h41, 1'b0};
        vecs[2] = '{1'b1, 8'h86, 2'd0, 4'b0000, 1'b1, 2, 8'h41, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 2'd0, 4'b0100, 1'b1, 3, 8'h41, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 2'd0, 4'b0100, 1'b1, 2, 8'h05, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 2'd0, 4'b0100, 1'b1, 1, 8'h86, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 2'd0, 4'b0000, 1'b1, 0, 8'h00, 1'b0};
        vecs[7] = '{1'b1, 8'h12, 2'd0, 4'b0000, 1'b1, 0, 8'h00, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 2'd0, 4'b0000, 1'b1, 0, 8'h00, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 2'd0, 4'b0000, 1'b1, 0, 8'h00, 1'b0};

        reset     = 1'b0;
        in_valid  = 1'b0;
        flit      = 8'h00;
        vc_select = 2'd0;
        out_ready = 4'h0;
        m_inpkt   = 1'b0;
        m_cur     = 2'd0;
        m_perr    = 1'b0;
        #2;
        check("rst in_ready", int'(in_ready), 1);
        do_reset();

        for (int k = 0; k < 10; k++) begin
            drive(vecs[k].v, vecs[k].f, vecs[k].sel, vecs[k].ordy);
            check($sformatf("vec%0d in_ready", k), int'(in_ready), int'(vecs[k].exp_rdy));
            check($sformatf("vec%0d cnt2", k), cnt(2), vecs[k].exp_cnt2);
            check($sformatf("vec%0d perr", k), int'(proto_err), int'(vecs[k].exp_perr));
            if (vecs[k].exp_cnt2 != 0)
                check($sformatf("vec%0d flit2", k), int'(out_flit[23:16]), int'(vecs[k].exp_flit2));
        end

        // Backpressure: fill VC1, 5th flit refused even with a concurrent pop.
        drive(1'b1, 8'h41, 2'd1, 4'b0000);
        drive(1'b1, 8'h01, 2'd0, 4'b0000);
        drive(1'b1, 8'h02, 2'd0, 4'b0000);
        drive(1'b1, 8'h03, 2'd0, 4'b0000);
        drive(1'b1, 8'h04, 2'd0, 4'b0010);
        check("full in_ready", int'(in_ready), 0);
        check("full cnt1", cnt(1), 4);
        drive(1'b1, 8'h04, 2'd0, 4'b0000);
        check("after pop in_ready", int'(in_ready), 1);
        check("after pop cnt1", cnt(1), 3);
        drive(1'b0, 8'h00, 2'd0, 4'b0010);
        drive(1'b1, 8'h85, 2'd0, 4'b0000);
        drain();

        // Pointer wrap: 20 singles through VC3 with continuous pop.
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 8'hC0 + 8'(k), 2'd3, 4'b1000);
            n_cmp++;
            if (cnt(3) > 1) begin
                n_err++;
                $display("FAIL wrap cnt3: got %0d expected <=1 at %0t", cnt(3), $time);
            end
        end
        drive(1'b0, 8'h00, 2'd0, 4'b1000);
        check("wrap empty", int'(q3.size()), 0);
        drive(1'b0, 8'h00, 2'd0, 4'b0000);

        // Interleaved: bodies carry vc_select=0 but belong to VC3.
        drive(1'b1, 8'hC7, 2'd0, 4'b0000);
        drive(1'b1, 8'h43, 2'd3, 4'b0000);
        drive(1'b1, 8'h0A, 2'd0, 4'b0000);
        drive(1'b1, 8'h0B, 2'd0, 4'b0000);
        drive(1'b1, 8'h8C, 2'd0, 4'b0000);
        drive(1'b0, 8'h00, 2'd0, 4'b0000);
        check("ilv cnt0", cnt(0), 1);
        check("ilv cnt3", cnt(3), 4);
        drain();

        // Framing error inside a packet: stray head dropped, tail to original VC.
        drive(1'b1, 8'h41, 2'd1, 4'b0000);
        drive(1'b1, 8'h42, 2'd2, 4'b0000);
        drive(1'b0, 8'h00, 2'd0, 4'b0000);
        check("inpkt perr", int'(proto_err), 1);
        drive(1'b1, 8'h83, 2'd2, 4'b0000);
        drive(1'b0, 8'h00, 2'd0, 4'b0000);
        check("inpkt cnt1", cnt(1), 2);
        check("inpkt cnt2", cnt(2), 0);
        drain();

        // Reset mid-packet, then a body must be flagged.
        drive(1'b1, 8'h41, 2'd1, 4'b0000);
        drive(1'b1, 8'h06, 2'd0, 4'b0000);
        drive(1'b1, 8'h07, 2'd0, 4'b0000);
        in_valid = 1'b0;
        do_reset();
        drive(1'b1, 8'h08, 2'd0, 4'b0000);
        drive(1'b0, 8'h00, 2'd0, 4'b0000);
        check("post-rst perr", int'(proto_err), 1);
        check("post-rst cnt1", cnt(1), 0);
        drive(1'b0, 8'h00, 2'd0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
